// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The state encoding lives here so the top and any future siblings agree on it.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

  // Bit counter width; W >= 2 guarantees at least one bit.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result bundle for serial_subtractor.
// master = producer/consumer side, slave = the subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );

endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: x - y - br -> d with borrow-out bo.
// Purely combinational; the serial datapath reuses it once per bit.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ br;
  assign bo = (~x & y) | (~(x ^ y) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock, between a
// valid/ready producer and consumer. One operation in flight at a time.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW       = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        state_reg;
  logic [W-1:0]  sa_reg;
  logic [W-1:0]  sb_reg;
  logic [W-1:0]  diff_reg;
  logic          br_reg;
  logic          bout_reg;
  logic [CW-1:0] cnt_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          busy_reg;

  logic cell_d;
  logic cell_bo;

  full_subtractor_bit u_bit (
    .x  (sa_reg[0]),
    .y  (sb_reg[0]),
    .br (br_reg),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result bits are shifted into the top of sa as minuend bits leave the
  // bottom, so the minuend register doubles as the result shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sa_reg        <= '0;
      sb_reg        <= '0;
      diff_reg      <= '0;
      br_reg        <= 1'b0;
      bout_reg      <= 1'b0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            sa_reg       <= bus.a;
            sb_reg       <= bus.b;
            br_reg       <= bus.bin;
            cnt_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sa_reg  <= {cell_d, sa_reg[W-1:1]};
          sb_reg  <= {1'b0, sb_reg[W-1:1]};
          br_reg  <= cell_bo;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= DONE;
            diff_reg      <= {cell_d, sa_reg[W-1:1]};
            bout_reg      <= cell_bo;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_valid_reg && bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.busy      = busy_reg;

endmodule
